// File: rtl/servo_pkg.sv
// Shared constants, duty types and the duty clamp helper for the servo PWM slice.
// Latency: n/a (package only).
// Backpressure: n/a.
package servo_pkg;

    localparam int DUTY_W = 10;

    // Production defaults: 25 MHz clock, 32 us per duty unit, 20 ms frame.
    localparam int DEF_TICK_CYCLES  = 800;
    localparam int DEF_PERIOD_TICKS = 625;
    localparam int DEF_DUTY_MIN     = 15;
    localparam int DEF_DUTY_MAX     = 75;
    localparam int DEF_DUTY_RESET   = 45;
    localparam int DEF_SLEW_STEP    = 2;

    typedef logic [DUTY_W-1:0] duty_t;
    // One extra bit so stepping near 0 or full scale cannot wrap.
    typedef logic [DUTY_W:0]   duty_ext_t;

    function automatic duty_ext_t clamp_duty(input duty_t d, input int lo, input int hi);
        duty_ext_t de;
        de = {1'b0, d};
        if (de < duty_ext_t'(lo)) begin
            return duty_ext_t'(lo);
        end
        if (de > duty_ext_t'(hi)) begin
            return duty_ext_t'(hi);
        end
        return de;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Frame timebase: sub_cnt divides the clock into duty units, frame_tick counts units per frame.
// Latency: frame_last/frame_start are combinational from the counters; frame_tick_nxt is the next-state value.
// Backpressure: none, free-running.
// Ports: clk25mhz, reset (sync, active-high) in; frame_tick_nxt, frame_last, frame_start out.
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int TICK_CYCLES  = DEF_TICK_CYCLES,
    parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
    localparam int SUB_W  = (TICK_CYCLES  > 1) ? $clog2(TICK_CYCLES)  : 1,
    localparam int TICK_W = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1
) (
    input  logic              clk25mhz,
    input  logic              reset,
    output logic [TICK_W-1:0] frame_tick_nxt,
    output logic              frame_last,
    output logic              frame_start
);

    logic [SUB_W-1:0]  sub_cnt;
    logic [SUB_W-1:0]  sub_cnt_nxt;
    logic [TICK_W-1:0] frame_tick;
    logic              sub_wrap;

    assign sub_wrap   = (sub_cnt == SUB_W'(TICK_CYCLES - 1));
    assign frame_last = sub_wrap && (frame_tick == TICK_W'(PERIOD_TICKS - 1));

    // Gated by reset so the pulse is absent while held in reset yet present on
    // the very first cycle after release, when both counters sit at zero.
    assign frame_start = !reset && (sub_cnt == '0) && (frame_tick == '0);

    always_comb begin
        sub_cnt_nxt    = sub_wrap ? '0 : sub_cnt + SUB_W'(1);
        frame_tick_nxt = frame_tick;
        if (frame_last) begin
            frame_tick_nxt = '0;
        end else if (sub_wrap) begin
            frame_tick_nxt = frame_tick + TICK_W'(1);
        end
    end

    always_ff @(posedge clk25mhz) begin
        if (reset) begin
            sub_cnt    <= '0;
            frame_tick <= '0;
        end else begin
            sub_cnt    <= sub_cnt_nxt;
            frame_tick <= frame_tick_nxt;
        end
    end

endmodule

// File: rtl/servo_pwm_slew.sv
// Servo PWM stage: clamps and slew-limits the target duty, applies it only at frame boundaries.
// Latency: new duty/enable visible in the frame after the boundary that samples them; servoSignal registered, aligned with frame_start.
// Backpressure: none; duty_cycle_input and enable are sampled once per frame and otherwise ignored.
// Ports: clk25mhz, reset, enable, duty_cycle_input[9:0] in; servoSignal, active_duty[9:0], at_target, frame_start out.
module servo_pwm_slew
    import servo_pkg::*;
#(
    parameter int TICK_CYCLES  = DEF_TICK_CYCLES,
    parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
    parameter int DUTY_MIN     = DEF_DUTY_MIN,
    parameter int DUTY_MAX     = DEF_DUTY_MAX,
    parameter int DUTY_RESET   = DEF_DUTY_RESET,
    parameter int SLEW_STEP    = DEF_SLEW_STEP
) (
    input  logic              clk25mhz,
    input  logic              reset,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_cycle_input,
    output logic              servoSignal,
    output logic [DUTY_W-1:0] active_duty,
    output logic              at_target,
    output logic              frame_start
);

    localparam int TICK_W = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;

    logic [TICK_W-1:0] frame_tick_nxt;
    logic              frame_last;

    duty_ext_t tgt;
    duty_ext_t cur;
    duty_ext_t diff;
    duty_ext_t step;
    duty_ext_t duty_nxt;
    logic      gate_en;
    logic      gate_nxt;
    logic      going_up;

    servo_frame_timer #(
        .TICK_CYCLES  (TICK_CYCLES),
        .PERIOD_TICKS (PERIOD_TICKS)
    ) u_timer (
        .clk25mhz       (clk25mhz),
        .reset          (reset),
        .frame_tick_nxt (frame_tick_nxt),
        .frame_last     (frame_last),
        .frame_start    (frame_start)
    );

    // Step toward the clamped target by at most SLEW_STEP; a zero step size
    // means jump straight there. Taking the smaller of |diff| and the step
    // prevents overshoot.
    always_comb begin
        tgt      = clamp_duty(duty_cycle_input, DUTY_MIN, DUTY_MAX);
        cur      = {1'b0, active_duty};
        going_up = (tgt >= cur);
        diff     = going_up ? (tgt - cur) : (cur - tgt);
        step     = diff;
        if ((SLEW_STEP != 0) && (diff > duty_ext_t'(SLEW_STEP))) begin
            step = duty_ext_t'(SLEW_STEP);
        end
        duty_nxt = cur;
        gate_nxt = gate_en;
        if (frame_last) begin
            duty_nxt = going_up ? (cur + step) : (cur - step);
            gate_nxt = enable;
        end
    end

    // servoSignal is computed from next-state values so the first high cycle
    // of a frame coincides with frame_start instead of lagging by one clock.
    always_ff @(posedge clk25mhz) begin
        if (reset) begin
            active_duty <= DUTY_W'(DUTY_RESET);
            gate_en     <= 1'b0;
            servoSignal <= 1'b0;
            at_target   <= 1'b0;
        end else begin
            active_duty <= duty_nxt[DUTY_W-1:0];
            gate_en     <= gate_nxt;
            servoSignal <= gate_nxt && (32'(frame_tick_nxt) < 32'(duty_nxt));
            if (frame_last) begin
                at_target <= (duty_nxt == tgt);
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_slew.sv
module tb_servo_pwm_slew;

    localparam int FRAME = 80;  // 4 clk per unit * 20 units

    logic       clk25mhz = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [9:0] duty_cycle_input = 10'd5;

    logic       servo_a, at_a, fs_a;
    logic [9:0] ad_a;
    logic       servo_b, at_b, fs_b;
    logic [9:0] ad_b;

    logic       sel = 1'b0;
    logic       m_servo, m_at, m_fs;
    logic [9:0] m_ad;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk25mhz = ~clk25mhz;

    servo_pwm_slew #(
        .TICK_CYCLES(4), .PERIOD_TICKS(20), .DUTY_MIN(2), .DUTY_MAX(15),
        .DUTY_RESET(5), .SLEW_STEP(2)
    ) dut (
        .clk25mhz(clk25mhz), .reset(reset), .enable(enable),
        .duty_cycle_input(duty_cycle_input), .servoSignal(servo_a),
        .active_duty(ad_a), .at_target(at_a), .frame_start(fs_a)
    );

    servo_pwm_slew #(
        .TICK_CYCLES(4), .PERIOD_TICKS(20), .DUTY_MIN(2), .DUTY_MAX(15),
        .DUTY_RESET(5), .SLEW_STEP(0)
    ) dut_jump (
        .clk25mhz(clk25mhz), .reset(reset), .enable(enable),
        .duty_cycle_input(duty_cycle_input), .servoSignal(servo_b),
        .active_duty(ad_b), .at_target(at_b), .frame_start(fs_b)
    );

    assign m_servo = sel ? servo_b : servo_a;
    assign m_at    = sel ? at_b    : at_a;
    assign m_fs    = sel ? fs_b    : fs_a;
    assign m_ad    = sel ? ad_b    : ad_a;

    // Bounded wait for frame_start, sampled on the falling edge.
    task automatic sync_frame(input string where);
        int n = 0;
        while (!m_fs && n < 200) begin
            @(negedge clk25mhz);
            n++;
        end
        vectors++;
        if (m_fs !== 1'b1) begin
            miscompares++;
            $display("FAIL %s sync: frame_start not seen within 200 clk", where);
        end
    endtask

    // Observe one frame starting at the negedge of its frame_start cycle.
    // Optionally changes duty/enable at cycle chg_at. shape_ok covers: pulse
    // contiguous from cycle 0, frame_start only at cycle 0, active_duty steady.
    task automatic run_frame(input int chg_at, input logic [9:0] chg_duty, input logic chg_en,
                             output int hi, output logic shape_ok,
                             output logic [9:0] ad0, output logic at0);
        hi = 0;
        shape_ok = 1'b1;
        ad0 = m_ad;
        at0 = m_at;
        for (int i = 0; i < FRAME; i++) begin
            if (i == chg_at) begin
                duty_cycle_input = chg_duty;
                enable = chg_en;
            end
            if (m_servo === 1'b1) begin
                hi++;
                if (i != hi - 1) shape_ok = 1'b0;
            end
            if (m_fs !== (i == 0)) shape_ok = 1'b0;
            if (m_ad !== ad0) shape_ok = 1'b0;
            @(negedge clk25mhz);
        end
    endtask

    task automatic test_reset;
        int hi; logic ok; logic [9:0] ad; logic at;
        reset = 1'b1; enable = 1'b1; duty_cycle_input = 10'd5;
        repeat (3) @(negedge clk25mhz);
        vectors++; if (servo_a !== 1'b0) begin miscompares++; $display("FAIL reset_servo: got %b want 0", servo_a); end
        vectors++; if (ad_a !== 10'd5) begin miscompares++; $display("FAIL reset_duty: got %0d want 5", ad_a); end
        vectors++; if (at_a !== 1'b0) begin miscompares++; $display("FAIL reset_at: got %b want 0", at_a); end
        vectors++; if (fs_a !== 1'b0) begin miscompares++; $display("FAIL reset_fs: got %b want 0", fs_a); end
        @(posedge clk25mhz); #1 reset = 1'b0;
        @(negedge clk25mhz);
        vectors++; if (fs_a !== 1'b1) begin miscompares++; $display("FAIL first_fs: got %b want 1", fs_a); end
        run_frame(-1, 10'd0, 1'b1, hi, ok, ad, at);
        vectors++; if (hi != 0) begin miscompares++; $display("FAIL frame0_hi: got %0d want 0", hi); end
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL frame0_shape: got %b want 1", ok); end
    endtask

    task automatic test_basic;
        int hi; logic ok; logic [9:0] ad; logic at;
        for (int f = 0; f < 2; f++) begin
            run_frame(-1, 10'd0, 1'b1, hi, ok, ad, at);
            vectors++; if (hi != 20) begin miscompares++; $display("FAIL basic_hi[%0d]: got %0d want 20", f, hi); end
            vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL basic_shape[%0d]: got %b want 1", f, ok); end
            vectors++; if (ad !== 10'd5) begin miscompares++; $display("FAIL basic_duty[%0d]: got %0d want 5", f, ad); end
            vectors++; if (at !== 1'b1) begin miscompares++; $display("FAIL basic_at[%0d]: got %b want 1", f, at); end
        end
    endtask

    task automatic test_slew;
        int hi; logic ok; logic [9:0] ad; logic at;
        int exp_ad [3] = '{7, 9, 11};
        logic exp_at [3] = '{1'b0, 1'b0, 1'b1};
        run_frame(0, 10'd11, 1'b1, hi, ok, ad, at);
        vectors++; if (hi != 20) begin miscompares++; $display("FAIL slew_req_hi: got %0d want 20", hi); end
        for (int f = 0; f < 3; f++) begin
            run_frame(-1, 10'd0, 1'b1, hi, ok, ad, at);
            vectors++; if (ad !== 10'(exp_ad[f])) begin miscompares++; $display("FAIL slew_duty[%0d]: got %0d want %0d", f, ad, exp_ad[f]); end
            vectors++; if (hi != 4 * exp_ad[f]) begin miscompares++; $display("FAIL slew_hi[%0d]: got %0d want %0d", f, hi, 4 * exp_ad[f]); end
            vectors++; if (at !== exp_at[f]) begin miscompares++; $display("FAIL slew_at[%0d]: got %b want %b", f, at, exp_at[f]); end
            vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL slew_shape[%0d]: got %b want 1", f, ok); end
        end
    endtask

    task automatic test_clamp;
        int hi; logic ok; logic [9:0] ad; logic at;
        int e = 11;
        run_frame(0, 10'd0, 1'b1, hi, ok, ad, at);
        vectors++; if (hi != 44) begin miscompares++; $display("FAIL clamp_lo_req_hi: got %0d want 44", hi); end
        for (int f = 0; f < 6; f++) begin
            e = (e - 2 < 2) ? 2 : e - 2;
            run_frame(-1, 10'd0, 1'b1, hi, ok, ad, at);
            vectors++; if (ad !== 10'(e)) begin miscompares++; $display("FAIL clamp_lo_duty[%0d]: got %0d want %0d", f, ad, e); end
            vectors++; if (hi != 4 * e) begin miscompares++; $display("FAIL clamp_lo_hi[%0d]: got %0d want %0d", f, hi, 4 * e); end
            vectors++; if (at !== (e == 2)) begin miscompares++; $display("FAIL clamp_lo_at[%0d]: got %b want %b", f, at, (e == 2)); end
        end
        run_frame(0, 10'd1023, 1'b1, hi, ok, ad, at);
        vectors++; if (hi != 8) begin miscompares++; $display("FAIL clamp_min_hi: got %0d want 8", hi); end
        for (int f = 0; f < 8; f++) begin
            e = (e + 2 > 15) ? 15 : e + 2;
            run_frame(-1, 10'd0, 1'b1, hi, ok, ad, at);
            vectors++; if (ad !== 10'(e)) begin miscompares++; $display("FAIL clamp_hi_duty[%0d]: got %0d want %0d", f, ad, e); end
            vectors++; if (hi != 4 * e) begin miscompares++; $display("FAIL clamp_hi_hi[%0d]: got %0d want %0d", f, hi, 4 * e); end
        end
    endtask

    task automatic test_mid_change;
        int hi; logic ok; logic [9:0] ad; logic at;
        // Change at cycle 12 = frame_tick 3, well inside the 60 clk pulse.
        run_frame(12, 10'd13, 1'b1, hi, ok, ad, at);
        vectors++; if (hi != 60) begin miscompares++; $display("FAIL mid_hi: got %0d want 60", hi); end
        vectors++; if (ad !== 10'd15) begin miscompares++; $display("FAIL mid_duty: got %0d want 15", ad); end
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL mid_shape: got %b want 1", ok); end
        run_frame(-1, 10'd0, 1'b1, hi, ok, ad, at);
        vectors++; if (ad !== 10'd13) begin miscompares++; $display("FAIL mid_next_duty: got %0d want 13", ad); end
        vectors++; if (hi != 52) begin miscompares++; $display("FAIL mid_next_hi: got %0d want 52", hi); end
        vectors++; if (at !== 1'b1) begin miscompares++; $display("FAIL mid_next_at: got %b want 1", at); end
    endtask

    task automatic test_enable;
        int hi; logic ok; logic [9:0] ad; logic at;
        run_frame(20, 10'd13, 1'b0, hi, ok, ad, at);
        vectors++; if (hi != 52) begin miscompares++; $display("FAIL en_off_cur_hi: got %0d want 52", hi); end
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL en_off_cur_shape: got %b want 1", ok); end
        run_frame(0, 10'd13, 1'b1, hi, ok, ad, at);
        vectors++; if (hi != 0) begin miscompares++; $display("FAIL en_off_next_hi: got %0d want 0", hi); end
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL en_off_next_shape: got %b want 1", ok); end
        run_frame(-1, 10'd0, 1'b1, hi, ok, ad, at);
        vectors++; if (hi != 52) begin miscompares++; $display("FAIL en_resume_hi: got %0d want 52", hi); end
    endtask

    task automatic test_reset_mid;
        int hi; logic ok; logic [9:0] ad; logic at;
        sync_frame("reset_mid");
        repeat (10) @(negedge clk25mhz);
        vectors++; if (servo_a !== 1'b1) begin miscompares++; $display("FAIL rmid_pre_servo: got %b want 1", servo_a); end
        reset = 1'b1;
        @(negedge clk25mhz);
        vectors++; if (servo_a !== 1'b0) begin miscompares++; $display("FAIL rmid_servo: got %b want 0", servo_a); end
        vectors++; if (ad_a !== 10'd5) begin miscompares++; $display("FAIL rmid_duty: got %0d want 5", ad_a); end
        vectors++; if (at_a !== 1'b0) begin miscompares++; $display("FAIL rmid_at: got %b want 0", at_a); end
        duty_cycle_input = 10'd5; enable = 1'b1;
        @(posedge clk25mhz); #1 reset = 1'b0;
        @(negedge clk25mhz);
        vectors++; if (fs_a !== 1'b1) begin miscompares++; $display("FAIL rmid_fs: got %b want 1", fs_a); end
        run_frame(-1, 10'd0, 1'b1, hi, ok, ad, at);
        vectors++; if (hi != 0) begin miscompares++; $display("FAIL rmid_frame0_hi: got %0d want 0", hi); end
    endtask

    task automatic test_no_slew;
        int hi; logic ok; logic [9:0] ad; logic at;
        duty_cycle_input = 10'd5; enable = 1'b1; reset = 1'b1;
        repeat (2) @(negedge clk25mhz);
        @(posedge clk25mhz); #1 reset = 1'b0;
        sel = 1'b1;
        @(negedge clk25mhz);
        sync_frame("no_slew");
        run_frame(-1, 10'd0, 1'b1, hi, ok, ad, at);
        vectors++; if (hi != 0) begin miscompares++; $display("FAIL jump_frame0_hi: got %0d want 0", hi); end
        run_frame(0, 10'd15, 1'b1, hi, ok, ad, at);
        vectors++; if (hi != 20) begin miscompares++; $display("FAIL jump_frame1_hi: got %0d want 20", hi); end
        vectors++; if (ad_a !== 10'd7) begin miscompares++; $display("FAIL jump_ref_slewed: got %0d want 7", ad_a); end
        run_frame(-1, 10'd0, 1'b1, hi, ok, ad, at);
        vectors++; if (ad !== 10'd15) begin miscompares++; $display("FAIL jump_duty: got %0d want 15", ad); end
        vectors++; if (hi != 60) begin miscompares++; $display("FAIL jump_hi: got %0d want 60", hi); end
        vectors++; if (at !== 1'b1) begin miscompares++; $display("FAIL jump_at: got %b want 1", at); end
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL jump_shape: got %b want 1", ok); end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slew();
        test_clamp();
        test_mid_change();
        test_enable();
        test_reset_mid();
        test_no_slew();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
